// File: rtl/mac_learn_table_aging.sv
// Learning MAC table with aging for the output-port-lookup path.
// Register-based, fully associative table. Each lookup resolves the egress
// mask for dst_mac and learns/refreshes src_mac against src_port.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dst_mac, src_mac           MACs to resolve / learn
//   src_port                   one-hot ingress port
//   lookup_req, lookup_ready   request handshake (sampled in IDLE)
//   flush                      single-cycle pulse, invalidates the table
//   dst_ports                  egress mask, valid with lookup_done
//   lookup_done, lut_hit, lut_miss  one-cycle result strobes
//   num_entries                number of valid entries
module mac_learn_table_aging #(
    parameter int unsigned                         NUM_OUTPUT_QUEUES         = 8,
    parameter int unsigned                         LUT_DEPTH_BITS            = 4,
    parameter logic [NUM_OUTPUT_QUEUES-1:0]        DEFAULT_MISS_OUTPUT_PORTS = 8'h55,
    parameter int unsigned                         AGE_BITS                  = 2,
    parameter int unsigned                         AGE_PERIOD                = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [47:0]                  dst_mac,
    input  logic [47:0]                  src_mac,
    input  logic [NUM_OUTPUT_QUEUES-1:0] src_port,
    input  logic                         lookup_req,
    input  logic                         flush,
    output logic                         lookup_ready,
    output logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic                         lookup_done,
    output logic                         lut_hit,
    output logic                         lut_miss,
    output logic [LUT_DEPTH_BITS:0]      num_entries
);

    localparam int unsigned LUT_DEPTH = 2 ** LUT_DEPTH_BITS;
    localparam int unsigned IDX_W     = LUT_DEPTH_BITS;
    localparam int unsigned CNT_W     = LUT_DEPTH_BITS + 1;
    localparam int unsigned PRE_W     = $clog2(AGE_PERIOD);
    localparam int unsigned GROUP_BIT = 40;
    localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(AGE_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MATCH   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    // Table storage
    logic [LUT_DEPTH-1:0]         valid;
    logic [47:0]                  mac_tab  [LUT_DEPTH];
    logic [NUM_OUTPUT_QUEUES-1:0] port_tab [LUT_DEPTH];
    logic [AGE_BITS-1:0]          age_tab  [LUT_DEPTH];

    // Lookup pipeline state
    state_t                       state, state_next;
    logic [47:0]                  dst_mac_q, src_mac_q;
    logic [NUM_OUTPUT_QUEUES-1:0] src_port_q;
    logic [LUT_DEPTH-1:0]         dst_match_q, src_match_q;
    logic [LUT_DEPTH-1:0]         dst_match_c, src_match_c;
    logic                         flush_seen;
    logic [IDX_W-1:0]             rr_ptr;
    logic [PRE_W-1:0]             prescaler;
    logic                         tick;

    // Decoded lookup results
    logic                         dst_hit, src_hit, free_any;
    logic [IDX_W-1:0]             dst_idx, src_idx, free_idx;
    logic [CNT_W-1:0]             count_c;

    // Next-state / control
    logic                         lat_en;
    logic                         done_next, hit_next, miss_next;
    logic [NUM_OUTPUT_QUEUES-1:0] ports_next;
    logic                         wr_en, rr_adv;
    logic [IDX_W-1:0]             wr_idx;

    assign tick = (prescaler == PRE_LAST);

    // Associative compare against the latched MACs
    always_comb begin
        dst_match_c = '0;
        src_match_c = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            dst_match_c[i] = valid[i] && (mac_tab[i] == dst_mac_q);
            src_match_c[i] = valid[i] && (mac_tab[i] == src_mac_q);
        end
    end

    // Lowest-index encoders for the match vectors and the first free slot
    always_comb begin
        dst_hit  = 1'b0;
        src_hit  = 1'b0;
        free_any = 1'b0;
        dst_idx  = '0;
        src_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (dst_match_q[i] && !dst_hit) begin
                dst_hit = 1'b1;
                dst_idx = IDX_W'(i);
            end
            if (src_match_q[i] && !src_hit) begin
                src_hit = 1'b1;
                src_idx = IDX_W'(i);
            end
            if (!valid[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Occupancy population count
    always_comb begin
        count_c = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            count_c = count_c + CNT_W'(valid[i]);
        end
    end

    // Next-state, result and learn decision
    always_comb begin
        state_next = state;
        lat_en     = 1'b0;
        done_next  = 1'b0;
        hit_next   = 1'b0;
        miss_next  = 1'b0;
        ports_next = dst_ports;
        wr_en      = 1'b0;
        wr_idx     = '0;
        rr_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (lookup_req) begin
                    lat_en     = 1'b1;
                    state_next = MATCH;
                end
            end
            MATCH: begin
                state_next = RESOLVE;
            end
            RESOLVE: begin
                state_next = IDLE;
                done_next  = 1'b1;
                if (dst_mac_q[GROUP_BIT]) begin
                    ports_next = DEFAULT_MISS_OUTPUT_PORTS & ~src_port_q;
                    miss_next  = 1'b1;
                end else if (dst_hit) begin
                    ports_next = port_tab[dst_idx] & ~src_port_q;
                    hit_next   = 1'b1;
                end else begin
                    ports_next = DEFAULT_MISS_OUTPUT_PORTS & ~src_port_q;
                    miss_next  = 1'b1;
                end
                // A flush during the lookup (or on this edge) cancels the learn
                if (!src_mac_q[GROUP_BIT] && !flush && !flush_seen) begin
                    wr_en = 1'b1;
                    if (src_hit) begin
                        wr_idx = src_idx;
                    end else if (free_any) begin
                        wr_idx = free_idx;
                    end else begin
                        wr_idx = rr_ptr;
                        rr_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lookup_ready <= 1'b1;
            dst_ports    <= '0;
            lookup_done  <= 1'b0;
            lut_hit      <= 1'b0;
            lut_miss     <= 1'b0;
            num_entries  <= '0;
        end else begin
            state        <= state_next;
            lookup_ready <= (state_next == IDLE);
            dst_ports    <= ports_next;
            lookup_done  <= done_next;
            lut_hit      <= hit_next;
            lut_miss     <= miss_next;
            num_entries  <= count_c;
        end
    end

    // Request latch, match vectors, flush tracking, pointer and prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_mac_q   <= '0;
            src_mac_q   <= '0;
            src_port_q  <= '0;
            dst_match_q <= '0;
            src_match_q <= '0;
            flush_seen  <= 1'b0;
            rr_ptr      <= '0;
            prescaler   <= '0;
        end else begin
            if (lat_en) begin
                dst_mac_q  <= dst_mac;
                src_mac_q  <= src_mac;
                src_port_q <= src_port;
            end
            if (state == MATCH) begin
                dst_match_q <= dst_match_c;
                src_match_q <= src_match_c;
            end
            // Cleared when a new lookup is accepted; remembers a flush seen mid-lookup
            if (lat_en) begin
                flush_seen <= 1'b0;
            end else if (flush) begin
                flush_seen <= 1'b1;
            end
            if (flush) begin
                rr_ptr <= '0;
            end else if (rr_adv) begin
                rr_ptr <= rr_ptr + IDX_W'(1);
            end
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    // Valid bits and ages: flush > learn write > aging tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                age_tab[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (flush) begin
                    valid[i] <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                    valid[i]   <= 1'b1;
                    age_tab[i] <= '0;
                end else if (tick && valid[i]) begin
                    if (age_tab[i] == AGE_MAX) begin
                        valid[i] <= 1'b0;
                    end else begin
                        age_tab[i] <= age_tab[i] + AGE_BITS'(1);
                    end
                end
            end
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mac_tab[wr_idx]  <= src_mac_q;
            port_tab[wr_idx] <= src_port_q;
        end
    end

endmodule

// File: tb/tb_mac_learn_table_aging.sv
// Directed bench for mac_learn_table_aging. Two instances share stimulus:
// dut_a never ages within the run, dut_b ages every 4 cycles.
module tb_mac_learn_table_aging;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] dst_mac, src_mac;
    logic [7:0]  src_port;
    logic        lookup_req, flush;

    logic       ready_a, done_a, hit_a, miss_a;
    logic [7:0] ports_a;
    logic [4:0] num_a;
    logic       ready_b, done_b, hit_b, miss_b;
    logic [7:0] ports_b;
    logic [4:0] num_b;

    logic       r_done_a, r_hit_a, r_miss_a, r_done_b, r_hit_b, r_miss_b;
    logic [7:0] r_ports_a, r_ports_b;

    int checks = 0;
    int errors = 0;
    int unsigned cyc;

    mac_learn_table_aging #(.AGE_PERIOD(1000000)) dut_a (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac),
        .src_port(src_port), .lookup_req(lookup_req), .flush(flush),
        .lookup_ready(ready_a), .dst_ports(ports_a), .lookup_done(done_a),
        .lut_hit(hit_a), .lut_miss(miss_a), .num_entries(num_a)
    );

    mac_learn_table_aging #(.AGE_PERIOD(4)) dut_b (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac),
        .src_port(src_port), .lookup_req(lookup_req), .flush(flush),
        .lookup_ready(ready_b), .dst_ports(ports_b), .lookup_done(done_b),
        .lut_hit(hit_b), .lut_miss(miss_b), .num_entries(num_b)
    );

    always #5 clk = ~clk;

    // Edges since reset release; dut_b ticks on edges where cyc % 4 == 3
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [47:0] mac(input logic [7:0] b);
        return {40'h0, b};
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // flush_at: 0 none, 1 pulse during MATCH, 2 pulse during RESOLVE
    task automatic lookup(input logic [47:0] d, input logic [47:0] s,
                          input logic [7:0] p, input int flush_at);
        dst_mac    = d;
        src_mac    = s;
        src_port   = p;
        lookup_req = 1'b1;
        cycles(1);
        lookup_req = 1'b0;
        if (flush_at == 1) flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        if (flush_at == 2) flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        r_done_a = done_a; r_hit_a = hit_a; r_miss_a = miss_a; r_ports_a = ports_a;
        r_done_b = done_b; r_hit_b = hit_b; r_miss_b = miss_b; r_ports_b = ports_b;
    endtask

    task automatic flush_idle();
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
        checks++; if ({hit_a, miss_a} !== 2'b00) begin errors++; $display("FAIL reset_hitmiss: got %b want 00", {hit_a, miss_a}); end
        checks++; if (ports_a !== 8'h00) begin errors++; $display("FAIL reset_ports: got %h want 00", ports_a); end
        checks++; if (num_a !== 5'd0) begin errors++; $display("FAIL reset_num: got %0d want 0", num_a); end
    endtask

    task automatic test_miss_learn();
        lookup(mac(8'h0A), mac(8'h0B), 8'h01, 0);
        checks++; if (r_done_a !== 1'b1) begin errors++; $display("FAIL first_done_latency: got %b want 1", r_done_a); end
        checks++; if (r_miss_a !== 1'b1 || r_hit_a !== 1'b0) begin errors++; $display("FAIL first_miss: got hit=%b miss=%b want 0/1", r_hit_a, r_miss_a); end
        checks++; if (r_ports_a !== 8'h54) begin errors++; $display("FAIL first_ports: got %h want 54", r_ports_a); end
        cycles(1);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", done_a); end
        checks++; if (num_a !== 5'd1) begin errors++; $display("FAIL first_num: got %0d want 1", num_a); end
    endtask

    task automatic test_hit_and_move();
        lookup(mac(8'h0B), mac(8'h0C), 8'h04, 0);
        checks++; if (r_hit_a !== 1'b1 || r_miss_a !== 1'b0) begin errors++; $display("FAIL hit_flag: got hit=%b miss=%b want 1/0", r_hit_a, r_miss_a); end
        checks++; if (r_ports_a !== 8'h01) begin errors++; $display("FAIL hit_ports: got %h want 01", r_ports_a); end
        lookup(mac(8'h0D), mac(8'h0B), 8'h10, 0);
        checks++; if (r_ports_a !== 8'h45 || r_miss_a !== 1'b1) begin errors++; $display("FAIL move_miss: got ports=%h miss=%b want 45/1", r_ports_a, r_miss_a); end
        lookup(mac(8'h0B), mac(8'h0C), 8'h04, 0);
        checks++; if (r_ports_a !== 8'h10 || r_hit_a !== 1'b1) begin errors++; $display("FAIL station_move: got ports=%h hit=%b want 10/1", r_ports_a, r_hit_a); end
        cycles(1);
        checks++; if (num_a !== 5'd2) begin errors++; $display("FAIL move_num: got %0d want 2", num_a); end
        lookup(mac(8'h0B), mac(8'h0C), 8'h10, 0);
        checks++; if (r_ports_a !== 8'h00 || r_hit_a !== 1'b1) begin errors++; $display("FAIL same_port_filter: got ports=%h hit=%b want 00/1", r_ports_a, r_hit_a); end
    endtask

    task automatic test_group();
        lookup(48'hFFFF_FFFF_FFFF, mac(8'h0C), 8'h04, 0);
        checks++; if (r_ports_a !== 8'h51 || r_miss_a !== 1'b1 || r_hit_a !== 1'b0) begin errors++; $display("FAIL broadcast: got ports=%h hit=%b miss=%b want 51/0/1", r_ports_a, r_hit_a, r_miss_a); end
        lookup(mac(8'h0B), 48'h0100_5E00_0001, 8'h02, 0);
        checks++; if (r_ports_a !== 8'h10 || r_hit_a !== 1'b1) begin errors++; $display("FAIL group_src_lookup: got ports=%h hit=%b want 10/1", r_ports_a, r_hit_a); end
        cycles(1);
        checks++; if (num_a !== 5'd2) begin errors++; $display("FAIL group_src_nolearn: got %0d want 2", num_a); end
        lookup(48'h0100_5E00_0001, mac(8'h0C), 8'h04, 0);
        checks++; if (r_ports_a !== 8'h51 || r_miss_a !== 1'b1) begin errors++; $display("FAIL multicast_dst: got ports=%h miss=%b want 51/1", r_ports_a, r_miss_a); end
    endtask

    task automatic test_aging();
        flush_idle();
        checks++; if (num_b !== 5'd0) begin errors++; $display("FAIL age_flush_num: got %0d want 0", num_b); end
        lookup(mac(8'h0A), mac(8'h0E), 8'h02, 0);
        cycles(1);
        checks++; if (num_b !== 5'd1) begin errors++; $display("FAIL age_learn_num: got %0d want 1", num_b); end
        cycles(11);
        checks++; if (num_b !== 5'd1) begin errors++; $display("FAIL age_still_valid: got %0d want 1", num_b); end
        cycles(8);
        checks++; if (num_b !== 5'd0) begin errors++; $display("FAIL age_evicted_num: got %0d want 0", num_b); end
        lookup(mac(8'h0E), mac(8'h0F), 8'h01, 0);
        checks++; if (r_miss_b !== 1'b1 || r_ports_b !== 8'h54) begin errors++; $display("FAIL age_evicted_miss: got miss=%b ports=%h want 1/54", r_miss_b, r_ports_b); end
        checks++; if (r_hit_a !== 1'b1 || r_ports_a !== 8'h02) begin errors++; $display("FAIL noage_hit: got hit=%b ports=%h want 1/02", r_hit_a, r_ports_a); end
        for (int k = 0; k < 6; k++) begin
            cycles(5);
            lookup(mac(8'h0A), mac(8'h0F), 8'h01, 0);
        end
        cycles(1);
        checks++; if (num_b !== 5'd1) begin errors++; $display("FAIL refresh_num: got %0d want 1", num_b); end
        lookup(mac(8'h0F), mac(8'h0A), 8'h02, 0);
        checks++; if (r_hit_b !== 1'b1 || r_ports_b !== 8'h01) begin errors++; $display("FAIL refresh_hit: got hit=%b ports=%h want 1/01", r_hit_b, r_ports_b); end
    endtask

    task automatic test_fill_replace();
        flush_idle();
        checks++; if (num_a !== 5'd0) begin errors++; $display("FAIL fill_start_num: got %0d want 0", num_a); end
        for (int i = 0; i < 16; i++) lookup(mac(8'h01), mac(8'(8'h10 + i)), 8'h01, 0);
        cycles(1);
        checks++; if (num_a !== 5'd16) begin errors++; $display("FAIL fill_full_num: got %0d want 16", num_a); end
        lookup(mac(8'h01), mac(8'h20), 8'h02, 0);
        cycles(1);
        checks++; if (num_a !== 5'd16) begin errors++; $display("FAIL replace_num: got %0d want 16", num_a); end
        lookup(mac(8'h10), mac(8'h20), 8'h02, 0);
        checks++; if (r_miss_a !== 1'b1 || r_ports_a !== 8'h55) begin errors++; $display("FAIL evicted_entry0: got miss=%b ports=%h want 1/55", r_miss_a, r_ports_a); end
        lookup(mac(8'h20), mac(8'h11), 8'h01, 0);
        checks++; if (r_hit_a !== 1'b1 || r_ports_a !== 8'h02) begin errors++; $display("FAIL replaced_hit: got hit=%b ports=%h want 1/02", r_hit_a, r_ports_a); end
        lookup(mac(8'h01), mac(8'h21), 8'h04, 0);
        lookup(mac(8'h11), mac(8'h21), 8'h04, 0);
        checks++; if (r_miss_a !== 1'b1 || r_ports_a !== 8'h51) begin errors++; $display("FAIL evicted_entry1: got miss=%b ports=%h want 1/51", r_miss_a, r_ports_a); end
        lookup(mac(8'h12), mac(8'h21), 8'h04, 0);
        checks++; if (r_hit_a !== 1'b1 || r_ports_a !== 8'h01) begin errors++; $display("FAIL entry2_kept: got hit=%b ports=%h want 1/01", r_hit_a, r_ports_a); end
    endtask

    task automatic test_flush();
        // Align so E2 of the next lookup coincides with a dut_b aging tick
        while (cyc % 4 != 1) cycles(1);
        lookup(mac(8'h12), mac(8'h30), 8'h08, 2);
        checks++; if (r_done_a !== 1'b1 || r_done_b !== 1'b1) begin errors++; $display("FAIL flush_e2_done: got a=%b b=%b want 1/1", r_done_a, r_done_b); end
        checks++; if (r_hit_a !== 1'b1 || r_ports_a !== 8'h01) begin errors++; $display("FAIL flush_e2_result: got hit=%b ports=%h want 1/01", r_hit_a, r_ports_a); end
        cycles(1);
        checks++; if (num_a !== 5'd0 || num_b !== 5'd0) begin errors++; $display("FAIL flush_e2_num: got a=%0d b=%0d want 0/0", num_a, num_b); end
        lookup(mac(8'h30), mac(8'h31), 8'h01, 0);
        checks++; if (r_miss_a !== 1'b1 || r_ports_a !== 8'h54 || r_miss_b !== 1'b1) begin errors++; $display("FAIL flush_e2_nolearn: got a_miss=%b ports=%h b_miss=%b want 1/54/1", r_miss_a, r_ports_a, r_miss_b); end
        lookup(mac(8'h31), mac(8'h32), 8'h02, 1);
        checks++; if (r_hit_a !== 1'b1 || r_ports_a !== 8'h01 || r_done_a !== 1'b1) begin errors++; $display("FAIL flush_e1_result: got hit=%b ports=%h done=%b want 1/01/1", r_hit_a, r_ports_a, r_done_a); end
        cycles(1);
        checks++; if (num_a !== 5'd0) begin errors++; $display("FAIL flush_e1_num: got %0d want 0", num_a); end
        lookup(mac(8'h32), mac(8'h33), 8'h01, 0);
        checks++; if (r_miss_a !== 1'b1 || r_ports_a !== 8'h54) begin errors++; $display("FAIL flush_e1_nolearn: got miss=%b ports=%h want 1/54", r_miss_a, r_ports_a); end
        // Pointer must restart at entry 0 after a flush
        flush_idle();
        for (int i = 0; i < 16; i++) lookup(mac(8'h01), mac(8'(8'h40 + i)), 8'h01, 0);
        lookup(mac(8'h01), mac(8'h50), 8'h01, 0);
        lookup(mac(8'h40), mac(8'h50), 8'h02, 0);
        checks++; if (r_miss_a !== 1'b1 || r_ports_a !== 8'h55) begin errors++; $display("FAIL flush_ptr_evict0: got miss=%b ports=%h want 1/55", r_miss_a, r_ports_a); end
        lookup(mac(8'h42), mac(8'h50), 8'h02, 0);
        checks++; if (r_hit_a !== 1'b1 || r_ports_a !== 8'h01) begin errors++; $display("FAIL flush_ptr_keep2: got hit=%b ports=%h want 1/01", r_hit_a, r_ports_a); end
    endtask

    task automatic test_back_to_back();
        lookup(mac(8'h01), mac(8'h60), 8'h08, 0);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", ready_a); end
        lookup(mac(8'h60), mac(8'h61), 8'h01, 0);
        checks++; if (r_done_a !== 1'b1 || r_hit_a !== 1'b1 || r_ports_a !== 8'h08) begin errors++; $display("FAIL b2b_sees_write: got done=%b hit=%b ports=%h want 1/1/08", r_done_a, r_hit_a, r_ports_a); end
        cycles(1);
        checks++; if (done_a !== 1'b0 || hit_a !== 1'b0) begin errors++; $display("FAIL b2b_strobe_width: got done=%b hit=%b want 0/0", done_a, hit_a); end
        checks++; if (ports_a !== 8'h08) begin errors++; $display("FAIL ports_hold: got %h want 08", ports_a); end
    endtask

    task automatic test_reset_abort();
        dst_mac    = mac(8'h60);
        src_mac    = mac(8'h62);
        src_port   = 8'h01;
        lookup_req = 1'b1;
        cycles(1);
        lookup_req = 1'b0;
        reset      = 1'b1;
        cycles(3);
        checks++; if (done_a !== 1'b0 || ready_a !== 1'b1 || num_a !== 5'd0) begin errors++; $display("FAIL reset_abort: got done=%b ready=%b num=%0d want 0/1/0", done_a, ready_a, num_a); end
        reset = 1'b0;
        cycles(1);
        lookup(mac(8'h60), mac(8'h63), 8'h01, 0);
        checks++; if (r_miss_a !== 1'b1 || r_ports_a !== 8'h54) begin errors++; $display("FAIL reset_cleared: got miss=%b ports=%h want 1/54", r_miss_a, r_ports_a); end
    endtask

    initial begin
        reset      = 1'b1;
        dst_mac    = '0;
        src_mac    = '0;
        src_port   = '0;
        lookup_req = 1'b0;
        flush      = 1'b0;
        cycles(2);
        test_reset();
        reset = 1'b0;
        test_miss_learn();
        test_hit_and_move();
        test_group();
        test_aging();
        test_fill_replace();
        test_flush();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_learn_table_aging.md
Name: mac_learn_table_aging

Overview:
- Parametrised learning MAC table for the switch output-port-lookup path. It has no external CAM core; it uses a register-based, fully associative table.
- Per lookup it resolves the destination ports for `dst_mac` and learns or refreshes `src_mac` against `src_port`.
- New capabilities: per-entry aging with automatic eviction, station-move update, a synchronous flush, group-address flooding, and an occupancy count.

Parameters:
- NUM_OUTPUT_QUEUES, 8: width of the one-hot port vectors.
- LUT_DEPTH_BITS, 4: log2 of the entry count. LUT_DEPTH = 2**LUT_DEPTH_BITS.
- DEFAULT_MISS_OUTPUT_PORTS, 8'h55: flood mask used on miss or group destination (MAC ports only, no CPU).
- AGE_BITS, 2: width of the per-entry age counter. AGE_MAX = 2**AGE_BITS-1.
- AGE_PERIOD, 1000000: clock cycles per aging tick. Must be ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- dst_mac  in  48  destination MAC to look up.
- src_mac  in  48  source MAC to learn.
- src_port  in  NUM_OUTPUT_QUEUES  one-hot ingress port.
- lookup_req  in  1  request; sampled only while lookup_ready=1.
- flush  in  1  single-cycle pulse; invalidates the whole table.
- lookup_ready  out  1  high in IDLE.
- dst_ports  out  NUM_OUTPUT_QUEUES  resolved egress mask; valid while lookup_done=1.
- lookup_done  out  1  one-cycle pulse.
- lut_hit  out  1  pulses with lookup_done on a unicast hit.
- lut_miss  out  1  pulses with lookup_done on a miss or group destination.
- num_entries  out  LUT_DEPTH_BITS+1  count of valid entries.

Behaviour:
- Entry format: {valid, mac[47:0], port[NUM_OUTPUT_QUEUES-1:0], age[AGE_BITS-1:0]}.
- Reset: all entries invalid. Round-robin pointer, prescaler and num_entries = 0. state=IDLE. lookup_ready=1. dst_ports, lookup_done, lut_hit, lut_miss = 0.
- No initialisation sweep is needed; broadcast and multicast are never stored.

FSM: IDLE -> MATCH -> RESOLVE -> IDLE.
- IDLE: if lookup_req, latch dst_mac, src_mac and src_port at edge E0 and go to MATCH.
- MATCH: compare the latched MACs against all valid entries. Register the dst match vector and the src match vector. Go to RESOLVE at E1.
- RESOLVE: compute the result and the learn action. At E2 register the outputs, commit the table write, and go to IDLE.
- lookup_done, lut_hit and lut_miss are high for exactly the cycle after E2.
- Throughput is one lookup per 3 cycles. A lookup sampled at E3 sees the write from E2.

Result:
- If dst_mac[40]=1 (group address, including all-ones): dst_ports = DEFAULT_MISS_OUTPUT_PORTS & ~src_port_latched. lut_miss=1.
- Else on a hit: dst_ports = entry.port & ~src_port_latched. lut_hit=1. The result can be 0, which means filtered on the same port.
- Else: dst_ports = DEFAULT_MISS_OUTPUT_PORTS & ~src_port_latched. lut_miss=1.
- dst_ports holds its value until the next lookup_done.

Learn, at E2:
- If src_mac[40]=1: no write.
- If src is found: set port = src_port_latched (station move) and age = 0.
- If src is not found: write {1, src_mac, src_port, 0} to the lowest-index invalid entry. If the table is full, write to the round-robin pointer and advance the pointer modulo LUT_DEPTH.

Aging:
- The prescaler counts 0..AGE_PERIOD-1 and wraps; tick = 1 at AGE_PERIOD-1.
- On a tick, every valid entry with age < AGE_MAX increments.
- On a tick, every valid entry with age == AGE_MAX becomes invalid.
- The prescaler runs in every state.

Simultaneous events, in priority order:
- flush beats learn and tick. flush clears all valid bits and the pointer at the next edge.
- If flush arrives during MATCH or RESOLVE, the in-flight lookup still completes with its result computed from pre-flush contents, but its learn write is suppressed.
- learn and tick together: the learned or refreshed entry gets age = 0 and stays valid. Other entries age normally.
- An entry evicted by a tick in the same edge as a learn miss is not counted as free for that learn.

Other rules:
- The match uses valid bits as registered at the start of MATCH.
- num_entries updates at the edge after any table change.
- Reset mid-lookup aborts the lookup: no lookup_done pulse, table cleared.

Test Plan:
- Reset, then lookup dst=00:00:00:00:00:0A, src=00:00:00:00:00:0B, src_port=8'h01 -> lookup_done 3 edges after req, lut_miss=1, dst_ports=8'h54, num_entries=1.
- Lookup dst=00:..:0B from src_port=8'h04, src=00:..:0C -> lut_hit=1, dst_ports=8'h01. Then src=00:..:0B from port 8'h10 -> the next lookup to 0B gives dst_ports=8'h10 (station move); num_entries unchanged.
- dst=FF:FF:FF:FF:FF:FF, src_port=8'h04 -> lut_miss=1, dst_ports=8'h51. Group src 01:00:5E:00:00:01 -> num_entries unchanged.
- AGE_PERIOD=4, AGE_BITS=2, learn one MAC, idle 16 cycles -> entry invalid, num_entries=0, next lookup misses. Refreshing every 8 cycles keeps it valid.
- Fill with LUT_DEPTH=16 distinct sources, learn a 17th -> entry 0 replaced, num_entries=16, the evicted MAC misses. An 18th replaces entry 1.
- Pulse flush in the same edge as a tick and an in-flight learn -> num_entries=0, all lookups miss, pointer=0, and the in-flight lookup_done is still issued.
